// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 arbiter with a registered output stage and valid/ready
// handshake toward a single downstream consumer.
module rr_mux_arbiter #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      req_i,
  input  logic [size-1:0] data0_i,
  input  logic [size-1:0] data1_i,
  input  logic [size-1:0] data2_i,
  input  logic [size-1:0] data3_i,
  output logic [3:0]      gnt_o,
  output logic [1:0]      switch_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [size-1:0] mux_out_o,
  output logic [15:0]     xfer_cnt_o
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_ptr;
  logic [1:0]      r_sw;
  logic [size-1:0] r_data;
  logic [15:0]     r_cnt;

  logic [7:0]      w_dbl;
  logic [3:0]      w_rot;
  logic [1:0]      w_off;
  logic [1:0]      w_win;
  logic            w_any;
  logic            w_accept;
  logic            w_slot;
  logic            w_take;
  logic [size-1:0] w_wdata;

  // Rotate requests so that bit 0 is the current priority holder.
  assign w_dbl = {req_i, req_i} >> r_ptr;
  assign w_rot = w_dbl[3:0];
  assign w_any = |req_i;

  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  assign w_win    = r_ptr + w_off;
  assign w_accept = (r_state == S_FULL) & out_ready_i;
  assign w_slot   = (r_state == S_EMPTY) | w_accept;
  assign w_take   = rst_i & w_slot & w_any;

  always_comb begin
    w_wdata = data0_i;
    unique case (w_win)
      2'd0: w_wdata = data0_i;
      2'd1: w_wdata = data1_i;
      2'd2: w_wdata = data2_i;
      2'd3: w_wdata = data3_i;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: if (w_any) w_state_nxt = S_FULL;
      S_FULL:  if (out_ready_i && !w_any) w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_EMPTY;
      r_ptr   <= 2'd0;
      r_sw    <= 2'd0;
      r_data  <= '0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_data <= w_wdata;
        r_sw   <= w_win;
        r_ptr  <= w_win + 2'd1;
      end
      if (w_accept) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign gnt_o       = w_take ? (4'b0001 << w_win) : 4'b0000;
  assign switch_o    = r_sw;
  assign out_valid_o = (r_state == S_FULL);
  assign mux_out_o   = r_data;
  assign xfer_cnt_o  = r_cnt;

endmodule
